// File: rtl/bpm_pkg.sv
// Shared types and constants for the metronome tempo controller.
// Holds the BPM word type, FSM state enum and the saturating step helper.
package bpm_pkg;

  localparam int BPM_W        = 9;
  localparam int BPM_DISP_MAX = 299;
  localparam int STEP_W       = 4;
  localparam int ACCEL_AFTER  = 8;

  typedef logic [BPM_W-1:0]  bpm_t;
  typedef logic [BPM_W:0]    bpm_wide_t;
  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } bpm_state_e;

  localparam step_t STEP_FINE = 4'd1;
  localparam step_t STEP_FAST = 4'd10;

  // One extra bit of headroom so neither direction can wrap.
  function automatic bpm_t bpm_step(
    input bpm_t  v,
    input logic  up,
    input step_t st,
    input bpm_t  lo,
    input bpm_t  hi
  );
    bpm_wide_t w;
    if (up) begin
      w = {1'b0, v} + bpm_wide_t'(st);
      if (w > {1'b0, hi}) w = {1'b0, hi};
    end else begin
      w = {1'b0, v} - bpm_wide_t'(st);
      if (w[BPM_W] || (w < {1'b0, lo})) w = {1'b0, lo};
    end
    return w[BPM_W-1:0];
  endfunction

endpackage

// File: rtl/bpm_repeat_timer.sv
// Hold / auto-repeat interval timer for the tempo buttons.
// Loadable down-counter; expire is high in the last cycle of an interval.
module bpm_repeat_timer #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic sel,
  output logic expire
);

  localparam int unsigned MAX_C =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LD  = TW'(REPEAT_CYCLES - 1);

  logic [TW-1:0] count;
  logic          run;

  // Count down the selected interval; clr parks the timer idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      run   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      run   <= 1'b0;
    end else if (load) begin
      count <= sel ? REP_LD : HOLD_LD;
      run   <= 1'b1;
    end else if (run && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expire = run && (count == '0);

endmodule

// File: rtl/bpm_setting_ctrl.sv
// Tempo-setting controller: two buttons -> saturating BPM value.
// Optional BPM_ACCEL_EN: step grows to 10 after 8 auto-repeat steps.
module bpm_setting_ctrl
  import bpm_pkg::*;
#(
  parameter int unsigned BPM_MIN       = 30,
  parameter int unsigned BPM_MAX       = 299,
  parameter int unsigned BPM_DEFAULT   = 120,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_dec,
  output logic [BPM_W-1:0] bpm_value,
  output logic             bpm_changed,
  output logic             at_limit
);

  localparam bpm_t MIN_V = bpm_t'(BPM_MIN);
  localparam bpm_t MAX_V = bpm_t'(BPM_MAX);
  localparam bpm_t DEF_V = bpm_t'(BPM_DEFAULT);

  if ((BPM_MAX > BPM_DISP_MAX) || (BPM_MIN > BPM_MAX) ||
      (BPM_DEFAULT < BPM_MIN) || (BPM_DEFAULT > BPM_MAX) ||
      (HOLD_CYCLES == 0) || (REPEAT_CYCLES == 0)) begin : g_bad_cfg
    $error("bpm_setting_ctrl: illegal tempo parameters");
  end

  bpm_state_e state;
  logic       dir;
  logic       prev_inc;
  logic       prev_dec;
  logic       arm_inc;
  logic       arm_dec;

  logic       p_inc;
  logic       p_dec;
  logic       held;
  logic       other;

  logic       lock_req;
  logic       idle_step;
  logic       exp_step;
  logic       rel_req;

  logic       tmr_clr;
  logic       tmr_load;
  logic       tmr_sel;
  logic       tmr_exp;

  step_t      step_sz;
  bpm_t       idle_val;
  bpm_t       rep_val;

  // A press needs the button low last cycle and seen low since reset.
  always_comb begin
    p_inc = btn_inc & ~prev_inc & arm_inc;
    p_dec = btn_dec & ~prev_dec & arm_dec;
    held  = dir ? btn_inc : btn_dec;
    other = dir ? btn_dec : btn_inc;
  end

  // Next-state decisions shared by the FSM and the timer controls.
  always_comb begin
    lock_req  = 1'b0;
    idle_step = 1'b0;
    exp_step  = 1'b0;
    rel_req   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        lock_req  = btn_inc & btn_dec & (p_inc | p_dec);
        idle_step = ~lock_req & (p_inc ^ p_dec);
      end
      (state == HOLD) || (state == REPEAT): begin
        rel_req  = ~held;
        lock_req = held & other;
        exp_step = held & ~other & tmr_exp;
      end
      (state == LOCK): begin
        rel_req = ~btn_inc & ~btn_dec;
      end
      default: ;
    endcase
  end

  // Timer reloads on every step and is parked on any exit.
  always_comb begin
    tmr_load = idle_step | exp_step;
    tmr_sel  = exp_step;
    tmr_clr  = rel_req | lock_req;
  end

  bpm_repeat_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .load  (tmr_load),
    .sel   (tmr_sel),
    .expire(tmr_exp)
  );

`ifdef BPM_ACCEL_EN
  logic [3:0] rep_cnt;

  // Auto-repeat steps taken in this hold, saturating at 15.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (idle_step) begin
      rep_cnt <= '0;
    end else if (exp_step && (rep_cnt != 4'hF)) begin
      rep_cnt <= rep_cnt + 4'd1;
    end
  end

  assign step_sz = (rep_cnt >= 4'(ACCEL_AFTER)) ? STEP_FAST : STEP_FINE;
`else
  assign step_sz = STEP_FINE;
`endif

  // Candidate values for a first press and for an auto-repeat step.
  always_comb begin
    idle_val = bpm_step(bpm_value, p_inc, STEP_FINE, MIN_V, MAX_V);
    rep_val  = bpm_step(bpm_value, dir, step_sz, MIN_V, MAX_V);
  end

  // Main FSM with registered tempo and change pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bpm_value   <= DEF_V;
      bpm_changed <= 1'b0;
      dir         <= 1'b0;
      prev_inc    <= 1'b0;
      prev_dec    <= 1'b0;
      arm_inc     <= 1'b0;
      arm_dec     <= 1'b0;
    end else begin
      prev_inc    <= btn_inc;
      prev_dec    <= btn_dec;
      arm_inc     <= arm_inc | ~btn_inc;
      arm_dec     <= arm_dec | ~btn_dec;
      bpm_changed <= 1'b0;
      unique case (1'b1)
        lock_req: begin
          bpm_value   <= DEF_V;
          bpm_changed <= (bpm_value != DEF_V);
          state       <= LOCK;
        end
        idle_step: begin
          bpm_value   <= idle_val;
          bpm_changed <= (idle_val != bpm_value);
          dir         <= p_inc;
          state       <= HOLD;
        end
        exp_step: begin
          bpm_value   <= rep_val;
          bpm_changed <= (rep_val != bpm_value);
          state       <= REPEAT;
        end
        rel_req: begin
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign at_limit = (bpm_value == MIN_V) || (bpm_value == MAX_V);

endmodule

// File: tb/tb_bpm_setting_ctrl.sv
// Bench for bpm_setting_ctrl with short hold/repeat intervals.
// Vector table, directed corners and a random run against a timing model.
module tb_bpm_setting_ctrl;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int VMIN = 30;
  localparam int VMAX = 299;
  localparam int VDEF = 120;

  logic       clk;
  logic       rst;
  logic       btn_inc;
  logic       btn_dec;
  logic [8:0] bpm_value;
  logic       bpm_changed;
  logic       at_limit;

  int tests;
  int fails;

  bpm_setting_ctrl #(
    .BPM_MIN      (VMIN),
    .BPM_MAX      (VMAX),
    .BPM_DEFAULT  (VDEF),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .bpm_value  (bpm_value),
    .bpm_changed(bpm_changed),
    .at_limit   (at_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: mode 0 idle, 1 holding, 2 locked; t = edges since press.
  int m_val;
  bit m_chg;
  int m_mode;
  bit m_up;
  int m_t;
  bit m_pi, m_pd, m_si, m_sd;

  function automatic int sat(input int v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  task automatic set_val(input int n);
    m_chg = (n != m_val);
    m_val = n;
  endtask

  task automatic model_reset();
    m_val  = VDEF;
    m_chg  = 1'b0;
    m_mode = 0;
    m_up   = 1'b0;
    m_t    = 0;
    m_pi   = 1'b0;
    m_pd   = 1'b0;
    m_si   = 1'b0;
    m_sd   = 1'b0;
  endtask

  task automatic model_edge(input bit inc, input bit dec);
    bit pi, pd, hb, ob;
    pi    = inc && !m_pi && m_si;
    pd    = dec && !m_pd && m_sd;
    m_chg = 1'b0;
    if (m_mode == 0) begin
      if (inc && dec && (pi || pd)) begin
        set_val(VDEF);
        m_mode = 2;
      end else if (pi != pd) begin
        m_up = pi;
        set_val(sat(m_val + (pi ? 1 : -1)));
        m_t    = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      hb = m_up ? inc : dec;
      ob = m_up ? dec : inc;
      if (!hb) begin
        m_mode = 0;
      end else if (ob) begin
        set_val(VDEF);
        m_mode = 2;
      end else begin
        m_t++;
        if (m_t == HOLD || (m_t > HOLD && ((m_t - HOLD) % REP) == 0))
          set_val(sat(m_val + (m_up ? 1 : -1)));
      end
    end else begin
      if (!inc && !dec) m_mode = 0;
    end
    m_pi = inc;
    m_pd = dec;
    m_si = m_si | !inc;
    m_sd = m_sd | !dec;
  endtask

  task automatic check(input string name, input int ev, input bit ec,
                       input bit el);
    logic [8:0] evb;
    evb = ev[8:0];
    tests++;
    if (ev < 0 || ev > 511 || bpm_value !== evb ||
        bpm_changed !== ec || at_limit !== el) begin
      fails++;
      $display("FAIL %s: got bpm=%0d chg=%b lim=%b, want bpm=%0d chg=%b lim=%b",
               name, bpm_value, bpm_changed, at_limit, ev, ec, el);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_val, m_chg, (m_val == VMIN) || (m_val == VMAX));
  endtask

  task automatic bound_fail(input string name, input int got);
    tests++;
    fails++;
    $display("FAIL %s: loop bound hit, model bpm=%0d", name, got);
  endtask

  // Drive inputs, clock once, advance the model; sampled 1 unit after edge.
  task automatic apply(input bit inc, input bit dec);
    btn_inc = inc;
    btn_dec = dec;
    @(posedge clk);
    model_edge(inc, dec);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic reset_release();
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit r;
    bit inc;
    bit dec;
    int val;
    bit chg;
    bit lim;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit i, input bit d,
                     input int v, input bit c, input bit l);
    vec_t e;
    e.r   = r;
    e.inc = i;
    e.dec = d;
    e.val = v;
    e.chg = c;
    e.lim = l;
    tbl.push_back(e);
  endtask

  initial begin
    int n;
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Single press, then a 12-cycle hold from the default tempo.
    add(1, 0, 0, 120, 0, 0);
    add(0, 0, 0, 120, 0, 0);
    add(0, 1, 0, 121, 1, 0);
    add(0, 0, 0, 121, 0, 0);
    add(0, 0, 0, 121, 0, 0);
    add(1, 0, 0, 120, 0, 0);
    add(0, 0, 0, 120, 0, 0);
    add(0, 1, 0, 121, 1, 0);
    add(0, 1, 0, 121, 0, 0);
    add(0, 1, 0, 121, 0, 0);
    add(0, 1, 0, 121, 0, 0);
    add(0, 1, 0, 122, 1, 0);
    add(0, 1, 0, 122, 0, 0);
    add(0, 1, 0, 123, 1, 0);
    add(0, 1, 0, 123, 0, 0);
    add(0, 1, 0, 124, 1, 0);
    add(0, 1, 0, 124, 0, 0);
    add(0, 1, 0, 125, 1, 0);
    add(0, 1, 0, 125, 0, 0);
    add(0, 0, 0, 125, 0, 0);
    add(0, 0, 0, 125, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].r) begin
        btn_inc = tbl[i].inc;
        btn_dec = tbl[i].dec;
        reset_pulse();
        check($sformatf("vec%0d_rst", i), tbl[i].val, tbl[i].chg, tbl[i].lim);
        reset_release();
      end else begin
        apply(tbl[i].inc, tbl[i].dec);
        check($sformatf("vec%0d", i), tbl[i].val, tbl[i].chg, tbl[i].lim);
      end
    end

    // Down to 31, then one more press saturates at 30 and stays.
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    reset_pulse();
    reset_release();
    apply(0, 0);
    n = 0;
    while (m_val != VMIN + 1 && n < 400) begin
      apply(0, 1);
      check_model("dec_to_31");
      n++;
    end
    if (n >= 400) bound_fail("dec_to_31", m_val);
    apply(0, 0);
    check("at_31", 31, 0, 0);
    apply(0, 1);
    check("hit_min", 30, 1, 1);
    for (int k = 0; k < 10; k++) begin
      apply(0, 1);
      check("min_hold", 30, 0, 1);
    end
    apply(0, 0);
    check("min_rel", 30, 0, 1);

    // Saturation at the top end.
    reset_pulse();
    reset_release();
    apply(0, 0);
    n = 0;
    while (m_val != VMAX && n < 500) begin
      apply(1, 0);
      check_model("inc_to_max");
      n++;
    end
    if (n >= 500) bound_fail("inc_to_max", m_val);
    for (int k = 0; k < 8; k++) begin
      apply(1, 0);
      check("max_hold", 299, 0, 1);
    end
    apply(0, 0);

    // Both buttons from 200 reload the default and lock.
    reset_pulse();
    reset_release();
    apply(0, 0);
    n = 0;
    while (m_val != 200 && n < 300) begin
      apply(1, 0);
      n++;
    end
    if (n >= 300) bound_fail("inc_to_200", m_val);
    apply(0, 0);
    check("at_200", 200, 0, 0);
    apply(1, 1);
    check("both_load", 120, 1, 0);
    for (int k = 0; k < 6; k++) begin
      apply(1, 1);
      check("lock_both", 120, 0, 0);
    end
    apply(0, 1);
    check("lock_dec", 120, 0, 0);
    apply(1, 0);
    check("lock_inc", 120, 0, 0);
    apply(0, 0);
    check("lock_rel", 120, 0, 0);
    apply(1, 0);
    check("after_lock", 121, 1, 0);
    apply(0, 0);

    // Reset during auto-repeat with the button still held.
    reset_pulse();
    reset_release();
    apply(0, 0);
    apply(1, 0);
    check("rp_press", 121, 1, 0);
    for (int k = 0; k < 6; k++) apply(1, 0);
    check("rp_repeat", 123, 1, 0);
    reset_pulse();
    check("rp_async", 120, 0, 0);
    reset_release();
    for (int k = 0; k < 5; k++) begin
      apply(1, 0);
      check("rp_held", 120, 0, 0);
    end
    apply(0, 0);
    check("rp_low", 120, 0, 0);
    apply(1, 0);
    check("rp_repress", 121, 1, 0);
    apply(0, 0);

    // Random button activity with rare resets against the model.
    for (int c = 0; c < 4000; c++) begin
      bit ni, nd;
      ni = btn_inc ^ ($urandom_range(0, 7) == 0);
      nd = btn_dec ^ ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) begin
        btn_inc = ni;
        btn_dec = nd;
        reset_pulse();
        check_model("rand_rst");
        reset_release();
      end else begin
        apply(ni, nd);
        check_model("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bpm_setting_ctrl.md
Name: bpm_setting_ctrl

Overview:
Tempo-setting controller for the metronome. It turns two debounced push-buttons into a saturating 9-bit BPM value, with press-and-hold auto-repeat and a both-buttons reset to the default tempo. Its bpm_value output drives the value input of the three-digit 7-segment display block and the beat generator.

Parameters:
BPM_MIN, 30, lowest tempo; the value saturates here.
BPM_MAX, 299, highest tempo; must be <= 299 (three-digit display limit).
BPM_DEFAULT, 120, value loaded at reset and on a both-buttons press.
HOLD_CYCLES, 25_000_000, clk cycles a button must stay held before auto-repeat starts.
REPEAT_CYCLES, 5_000_000, clk cycles between auto-repeat steps.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_inc  input  1  increment button; active-high, already synchronized and debounced
btn_dec  input  1  decrement button; active-high, already synchronized and debounced
bpm_value  output  9  current tempo, unsigned binary
bpm_changed  output  1  one-cycle pulse in the same cycle bpm_value takes a new value
at_limit  output  1  high while bpm_value == BPM_MIN or bpm_value == BPM_MAX

Behaviour:
- Reset (rst low, asynchronous):
  - bpm_value = BPM_DEFAULT, bpm_changed = 0.
  - at_limit reflects BPM_DEFAULT (combinational from bpm_value).
  - FSM = IDLE, timer = 0, previous-button registers = 0.
- Reset asserted mid-hold: aborts immediately. After release, a still-held button is not treated as a new press until it has been seen low.
- A "press" is a rising edge: input high while its registered previous sample is low.
- Step operation ("apply step"):
  - inc: new = min(bpm_value + STEP, BPM_MAX); dec: new = max(bpm_value - STEP, BPM_MIN).
  - Arithmetic is done in 10 bits so there is no wrap-around; STEP = 1.
  - bpm_changed pulses only if new != old.
- Latency: the step is applied on the clk edge following the cycle the press is detected (bpm_value is registered).
- FSM states:
  - IDLE:
    - Exactly one press (inc xor dec) -> apply step, timer = 0, go to HOLD, latch the direction.
    - Both buttons high in the same cycle, with at least one of them pressing -> load BPM_DEFAULT, go to LOCK.
  - HOLD:
    - Latched button low -> IDLE.
    - Other button goes high -> load BPM_DEFAULT, go to LOCK.
    - Timer reaches HOLD_CYCLES-1 -> apply step, timer = 0, go to REPEAT. Otherwise timer++.
  - REPEAT:
    - Same exits as HOLD.
    - Timer reaches REPEAT_CYCLES-1 -> apply step, timer = 0.
  - LOCK:
    - No steps are applied.
    - Stays until both buttons are low, then -> IDLE.
- Loading BPM_DEFAULT pulses bpm_changed only if the value actually differs.
- At saturation, auto-repeat keeps running but produces no change and no pulse.
- Timer width is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).

Optional Feature:
BPM_ACCEL_EN:
- Defined: the block counts auto-repeat steps in the current hold (saturating 4-bit counter, cleared on entering HOLD). After 8 repeat steps, STEP becomes 10, still saturating at BPM_MIN/BPM_MAX.
- Undefined: STEP is always 1, and no counter logic is present.

Decomposition:
- Package bpm_pkg:
  - BPM_W = 9.
  - typedef logic [BPM_W-1:0] bpm_t.
  - typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} bpm_state_e.
  - Display-safe limit constant BPM_DISP_MAX = 299.
- Sub-module bpm_repeat_timer:
  - Loadable down-counter with clear/start inputs and a one-cycle expire output.
  - Parameterized by HOLD_CYCLES and REPEAT_CYCLES, with a select between them.
  - The FSM and saturation logic stay in bpm_setting_ctrl.

Test Plan:
All scenarios use HOLD_CYCLES=4, REPEAT_CYCLES=2.
1. Release rst -> bpm_value=120, at_limit=0, bpm_changed=0.
2. Single btn_inc pulse for 1 cycle -> bpm_value=121 one cycle later, bpm_changed one-cycle pulse, no further change.
3. Hold btn_inc 12 cycles from 120 -> 121 at press; 122 after 4 more cycles; then +1 every 2 cycles; release stops steps.
4. Start at BPM_MIN+1=31 and hold btn_dec -> reaches 30, at_limit=1, further repeats give no bpm_changed pulse and no wrap to 511.
5. From 200, assert btn_inc and btn_dec in the same cycle -> 120, then no change while either is held. After both are released, a new btn_inc press gives 121.
6. Assert rst during REPEAT with btn_inc held -> bpm_value=120 immediately. After rst release with btn_inc still high, no step occurs until btn_inc goes low and high again.
